// File: rtl/alu_sequencer.sv
// Multi-cycle initiator for the datapath ALU: latches one request, holds the
// operands while the ALU settles, captures the wide result and writes it back.
module alu_sequencer #(
  parameter int EXEC_CYCLES = 1,
  parameter int DATA_WIDTH  = 32
) (
  input  logic                    clk,
  input  logic                    clr,
  input  logic                    start,
  input  logic [4:0]              op_in,
  input  logic [DATA_WIDTH-1:0]   a_in,
  input  logic [DATA_WIDTH-1:0]   b_in,
  output logic [4:0]              alu_op,
  output logic [DATA_WIDTH-1:0]   alu_a,
  output logic [DATA_WIDTH-1:0]   alu_b,
  input  logic [2*DATA_WIDTH-1:0] alu_c,
  output logic [DATA_WIDTH-1:0]   wb_data,
  output logic                    lo_we,
  output logic                    hi_we,
  output logic                    busy,
  output logic                    done,
  output logic                    err
);

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_SHR  = 5'b00101;
  localparam logic [4:0] OP_SHRA = 5'b00110;
  localparam logic [4:0] OP_SHL  = 5'b00111;
  localparam logic [4:0] OP_ROR  = 5'b01000;
  localparam logic [4:0] OP_ROL  = 5'b01001;
  localparam logic [4:0] OP_AND  = 5'b01010;
  localparam logic [4:0] OP_OR   = 5'b01011;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;

  localparam logic [3:0] CNT_INIT = 4'(EXEC_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_EXEC  = 3'd1,
    S_WB_LO = 3'd2,
    S_WB_HI = 3'd3,
    S_FIN   = 3'd4
  } state_t;

  // Latched request; y is the operand-A (Y) register.
  typedef struct packed {
    logic [4:0]            op;
    logic [DATA_WIDTH-1:0] y;
    logic [DATA_WIDTH-1:0] b;
  } req_t;

  state_t                  state_q, state_d;
  req_t                    req_q, req_d;
  logic [2*DATA_WIDTH-1:0] z_q, z_d;
  logic [3:0]              cnt_q, cnt_d;
  logic                    err_q, err_d;
  logic                    op_ok;
  logic                    wide_op;

  always_comb begin
    unique case (op_in)
      OP_ADD, OP_SUB, OP_SHR, OP_SHRA, OP_SHL, OP_ROR, OP_ROL,
      OP_AND, OP_OR, OP_MUL, OP_DIV, OP_NEG, OP_NOT: op_ok = 1'b1;
      default:                                        op_ok = 1'b0;
    endcase
  end

  assign wide_op = (req_q.op == OP_MUL) || (req_q.op == OP_DIV);

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= S_IDLE;
      req_q   <= '0;
      z_q     <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      z_q     <= z_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    z_d     = z_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          req_d.op = op_in;
          cnt_d    = CNT_INIT;
          err_d    = !op_ok;
          // Rejected requests never touch the ALU operand registers.
          if (op_ok) begin
            req_d.y = a_in;
            req_d.b = b_in;
            state_d = S_EXEC;
          end else begin
            state_d = S_FIN;
          end
        end
      end
      S_EXEC: begin
        if (cnt_q == '0) begin
          z_d     = alu_c;
          state_d = S_WB_LO;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_WB_LO: state_d = wide_op ? S_WB_HI : S_FIN;
      S_WB_HI: state_d = S_FIN;
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign alu_a = req_q.y;
  assign alu_b = req_q.b;

  always_comb begin
    alu_op  = '0;
    wb_data = '0;
    lo_we   = 1'b0;
    hi_we   = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    err     = 1'b0;
    unique case (state_q)
      S_EXEC: begin
        busy   = 1'b1;
        alu_op = req_q.op;
      end
      S_WB_LO: begin
        busy    = 1'b1;
        alu_op  = req_q.op;
        wb_data = z_q[DATA_WIDTH-1:0];
        lo_we   = 1'b1;
      end
      S_WB_HI: begin
        busy    = 1'b1;
        alu_op  = req_q.op;
        wb_data = z_q[2*DATA_WIDTH-1:DATA_WIDTH];
        hi_we   = 1'b1;
      end
      S_FIN: begin
        busy = 1'b1;
        done = 1'b1;
        err  = err_q;
        if (!err_q) alu_op = req_q.op;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: two instances (EXEC_CYCLES 1 and 4) each driving a
// behavioural ALU; per-cycle handshake expectations come from the latency rules.
module tb_alu_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]       clr, start;
  logic [1:0][4:0]  op_in, alu_op;
  logic [1:0][31:0] a_in, b_in, alu_a, alu_b, wb_data;
  logic [1:0][63:0] alu_c;
  logic [1:0]       lo_we, hi_we, busy, done, err;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] prev_a[2];
  logic [31:0] prev_b[2];

  logic [4:0] sup_ops[13] = '{5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9,
                              5'd10, 5'd11, 5'd15, 5'd16, 5'd17, 5'd18};

  // Behavioural ALU: also serves as the result reference.
  function automatic logic [63:0] alu_f(input logic [4:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    logic signed [63:0] p;
    logic signed [31:0] q, r;
    case (op)
      5'd3:  return {32'd0, a + b};
      5'd4:  return {32'd0, a - b};
      5'd5:  return {32'd0, a >> b[4:0]};
      5'd6:  return {32'd0, 32'($signed(a) >>> b[4:0])};
      5'd7:  return {32'd0, a << b[4:0]};
      5'd8:  return {32'd0, (a >> b[4:0]) | (a << (6'd32 - {1'b0, b[4:0]}))};
      5'd9:  return {32'd0, (a << b[4:0]) | (a >> (6'd32 - {1'b0, b[4:0]}))};
      5'd10: return {32'd0, a & b};
      5'd11: return {32'd0, a | b};
      5'd15: begin
        p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        return p;
      end
      5'd16: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
        return {r, q};
      end
      5'd17: return {32'd0, 32'd0 - a};
      5'd18: return {32'd0, ~a};
      default: return 64'd0;
    endcase
  endfunction

  function automatic bit is_sup(input logic [4:0] op);
    return op inside {5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9,
                      5'd10, 5'd11, 5'd15, 5'd16, 5'd17, 5'd18};
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    assign alu_c[g] = alu_f(alu_op[g], alu_a[g], alu_b[g]);
    alu_sequencer #(.EXEC_CYCLES(g == 0 ? 1 : 4), .DATA_WIDTH(32)) u_dut (
      .clk    (clk),
      .clr    (clr[g]),
      .start  (start[g]),
      .op_in  (op_in[g]),
      .a_in   (a_in[g]),
      .b_in   (b_in[g]),
      .alu_op (alu_op[g]),
      .alu_a  (alu_a[g]),
      .alu_b  (alu_b[g]),
      .alu_c  (alu_c[g]),
      .wb_data(wb_data[g]),
      .lo_we  (lo_we[g]),
      .hi_we  (hi_we[g]),
      .busy   (busy[g]),
      .done   (done[g]),
      .err    (err[g])
    );
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_zero(input int d, input string t);
    chk({t, " busy"},  64'(busy[d]),    64'd0);
    chk({t, " done"},  64'(done[d]),    64'd0);
    chk({t, " err"},   64'(err[d]),     64'd0);
    chk({t, " lo_we"}, 64'(lo_we[d]),   64'd0);
    chk({t, " hi_we"}, 64'(hi_we[d]),   64'd0);
    chk({t, " alu_op"},64'(alu_op[d]),  64'd0);
    chk({t, " wb"},    64'(wb_data[d]), 64'd0);
  endtask

  // One request on instance d; poke>0 re-pulses start in that cycle, poke<0 picks one.
  task automatic run_txn(input int d, input logic [4:0] op, input logic [31:0] a,
                         input logic [31:0] b, input int poke_in);
    int ex, dn, poke;
    bit sup, md;
    logic [63:0] res;
    string t;
    ex  = (d == 0) ? 1 : 4;
    sup = is_sup(op);
    md  = (op == 5'd15) || (op == 5'd16);
    res = alu_f(op, a, b);
    dn  = sup ? ex + 2 + int'(md) : 1;
    poke = (poke_in < 0) ? int'($urandom_range(1, dn)) : poke_in;
    @(negedge clk);
    start[d] = 1'b1; op_in[d] = op; a_in[d] = a; b_in[d] = b;
    @(posedge clk);
    for (int c = 1; c <= dn + 1; c++) begin
      @(negedge clk);
      start[d] = (c == poke);
      if (c == poke) begin op_in[d] = 5'd3; a_in[d] = $urandom; b_in[d] = $urandom; end
      t = $sformatf("d%0d op%0d c%0d", d, op, c);
      chk({t, " busy"},  64'(busy[d]),  64'(c <= dn));
      chk({t, " done"},  64'(done[d]),  64'(c == dn));
      chk({t, " err"},   64'(err[d]),   64'(!sup && c == dn));
      chk({t, " lo_we"}, 64'(lo_we[d]), 64'(sup && c == ex + 1));
      chk({t, " hi_we"}, 64'(hi_we[d]), 64'(sup && md && c == ex + 2));
      if (sup && c == ex + 1) chk({t, " wb_lo"}, 64'(wb_data[d]), 64'(res[31:0]));
      if (sup && md && c == ex + 2) chk({t, " wb_hi"}, 64'(wb_data[d]), 64'(res[63:32]));
      if (sup && c <= ex) begin
        chk({t, " alu_op"}, 64'(alu_op[d]), 64'(op));
        chk({t, " alu_a"},  64'(alu_a[d]),  64'(a));
        chk({t, " alu_b"},  64'(alu_b[d]),  64'(b));
      end
      if (!sup && c == 1) begin
        chk({t, " alu_op"}, 64'(alu_op[d]), 64'd0);
        chk({t, " alu_a"},  64'(alu_a[d]),  64'(prev_a[d]));
        chk({t, " alu_b"},  64'(alu_b[d]),  64'(prev_b[d]));
      end
      if (c == dn + 1) chk({t, " idle alu_op"}, 64'(alu_op[d]), 64'd0);
    end
    start[d] = 1'b0;
    if (sup) begin prev_a[d] = a; prev_b[d] = b; end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d;
    logic [4:0] op;
    logic [31:0] a, b;
    clr = 2'b11; start = '0; op_in = '0; a_in = '0; b_in = '0;
    prev_a[0] = '0; prev_a[1] = '0; prev_b[0] = '0; prev_b[1] = '0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk_idle_zero(i, $sformatf("reset d%0d", i));
      chk($sformatf("reset d%0d alu_a", i), 64'(alu_a[i]), 64'd0);
      chk($sformatf("reset d%0d alu_b", i), 64'(alu_b[i]), 64'd0);
    end
    clr = 2'b00;

    run_txn(0, 5'd3,  32'd5, 32'd7, 0);
    run_txn(0, 5'd15, 32'h0001_0000, 32'h0001_0000, 0);
    run_txn(0, 5'd16, 32'd7, 32'd2, 0);
    run_txn(0, 5'd16, 32'hFFFF_FFF9, 32'd2, 0);
    run_txn(0, 5'd16, 32'd9, 32'd0, 0);
    run_txn(0, 5'd2,  32'd11, 32'd12, 0);
    run_txn(1, 5'd4,  32'd3, 32'd10, 2);
    run_txn(0, 5'd3,  32'd9, 32'd4, 3);
    run_txn(1, 5'd20, 32'd1, 32'd1, 1);

    // Abort a mul while its LO strobe is up.
    @(negedge clk);
    start[0] = 1'b1; op_in[0] = 5'd15; a_in[0] = 32'h0001_0000; b_in[0] = 32'h0001_0000;
    @(posedge clk);
    @(negedge clk); start[0] = 1'b0;
    chk("abort c1 busy", 64'(busy[0]), 64'd1);
    @(negedge clk);
    chk("abort c2 lo_we", 64'(lo_we[0]), 64'd1);
    clr[0] = 1'b1;
    #1;
    chk_idle_zero(0, "abort clr");
    chk("abort clr alu_a", 64'(alu_a[0]), 64'd0);
    chk("abort clr alu_b", 64'(alu_b[0]), 64'd0);
    @(negedge clk); clr[0] = 1'b0;
    prev_a[0] = '0; prev_b[0] = '0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk_idle_zero(0, $sformatf("post-abort c%0d", c));
    end
    run_txn(0, 5'd3, 32'd1, 32'd1, 0);

    for (int i = 0; i < 24; i++) begin
      d = $urandom_range(0, 1);
      if ($urandom_range(0, 3) == 0) op = 5'($urandom_range(19, 31));
      else op = sup_ops[$urandom_range(0, 12)];
      a = $urandom;
      b = (op == 5'd16) ? 32'($urandom_range(1, 100)) : $urandom;
      run_txn(d, op, a, b, ($urandom_range(0, 1) == 0) ? 0 : -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
